pipe_stage_reg: RTL and testbench

- Parametrised pipeline boundary register, the generic successor to the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Captures a packed payload from upstream stage S and presents it to stage S+1.
- Obeys the central stall vector and adds a flush input, a valid bit and a configurable bubble value.
- Carries multi-cycle operation state (e.g. partial HI/LO product plus cycle count) across stall cycles.
- Exposes saturating hold and bubble counters for performance monitoring.

---
 rtl/pipe_stage_reg_pkg.sv | 52 +++++
 rtl/pipe_stage_reg_chk.sv | 15 +
 rtl/pipe_stage_reg_sat_counter.sv | 40 ++++
 rtl/pipe_stage_reg.sv | 134 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the generic pipeline boundary register:
// stall encodings, stage indices, NOP payload fields and the per-edge
// action decode used by the stage register.
package pipe_stage_reg_pkg;

   // Stall vector encoding
   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;

   // Stall bus width and type
   localparam int StallBusW = 6;
   typedef logic [StallBusW-1:0] stall_bus_t;

   // Stage indices within the stall vector
   localparam int STAGE_IF  = 1;
   localparam int STAGE_ID  = 2;
   localparam int STAGE_EX  = 3;
   localparam int STAGE_MEM = 4;
   localparam int STAGE_WB  = 5;

   // Fields that make up a NOP payload
   localparam logic [4:0]  NOPRegAddr   = 5'b00000;
   localparam logic        WriteDisable = 1'b0;
   localparam logic [31:0] ZeroWord     = 32'h0000_0000;

   // What the boundary register does on a given edge
   typedef enum logic [1:0] {
      ACT_FLUSH   = 2'd0,
      ACT_BUBBLE  = 2'd1,
      ACT_ADVANCE = 2'd2,
      ACT_HOLD    = 2'd3
   } stage_act_e;

   // Priority decode: flush, then bubble, then advance, then hold.
   // up=0 with dn=1 lands on advance on purpose.
   function automatic stage_act_e decode_act(input logic flush,
                                             input logic up,
                                             input logic dn);
      stage_act_e act;
      if (flush) begin
         act = ACT_FLUSH;
      end else if (up == Stop && dn == NoStop) begin
         act = ACT_BUBBLE;
      end else if (up == NoStop) begin
         act = ACT_ADVANCE;
      end else begin
         act = ACT_HOLD;
      end
      return act;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_chk.sv
// Simulation-side protocol checker: the stall controller must never stop a
// downstream stage while the upstream stage keeps running.
module pipe_stage_reg_chk (
   input logic clk,
   input logic rst,
   input logic up,
   input logic dn
);

   // Flag a running upstream stage feeding a stopped downstream stage
   a_no_up_run_dn_stop: assert property (
      @(posedge clk) disable iff (!rst) !((up == 1'b0) && (dn == 1'b1))
   ) else $warning("pipe_stage_reg: stall protocol violation, upstream running while downstream stopped");

endmodule

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter
   import pipe_stage_reg_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: clear, else increment unless already at the top value
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = {W{1'b0}};
      end else if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register, asynchronously cleared
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= {W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register between stage STAGE and STAGE+1.
// Handles flush, bubble insertion, hold, multi-cycle carry state and
// saturating hold/bubble performance counters.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int                   PAYLOAD_W   = 104,
   parameter int                   CARRY_W     = 66,
   parameter int                   STALL_W     = StallBusW,
   parameter int                   STAGE       = STAGE_EX,
   parameter int                   CNT_W       = 8,
   parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = {PAYLOAD_W{1'b0}}
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [STALL_W-1:0]   stall,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [PAYLOAD_W-1:0] in_payload,
   input  logic [CARRY_W-1:0]   carry_i,
   output logic                 out_valid,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic [CARRY_W-1:0]   carry_o,
   output logic [CNT_W-1:0]     hold_cnt,
   output logic [CNT_W-1:0]     bubble_cnt
);

   // The downstream stall bit must exist in the vector
   if (STAGE + 1 >= STALL_W) begin : g_bad_stage
      $error("pipe_stage_reg: STAGE+1 must be below STALL_W");
   end

   logic                 up_s;
   logic                 dn_s;
   stage_act_e           act_s;
   logic                 unused_stall_s;

   logic                 valid_q;
   logic                 valid_d;
   logic [PAYLOAD_W-1:0] payload_q;
   logic [PAYLOAD_W-1:0] payload_d;
   logic [CARRY_W-1:0]   carry_q;
   logic [CARRY_W-1:0]   carry_d;

   logic                 hold_inc_s;
   logic                 hold_clr_s;
   logic                 bubble_inc_s;

   assign up_s           = stall[STAGE];
   assign dn_s           = stall[STAGE+1];
   assign unused_stall_s = ^stall;
   assign act_s          = decode_act(flush, up_s, dn_s);

   // Next-state selection for the slot contents and counter controls
   always_comb begin
      valid_d      = valid_q;
      payload_d    = payload_q;
      carry_d      = carry_q;
      hold_inc_s   = 1'b0;
      hold_clr_s   = 1'b0;
      bubble_inc_s = 1'b0;
      case (act_s)
         ACT_FLUSH: begin
            valid_d    = 1'b0;
            payload_d  = NOP_PAYLOAD;
            carry_d    = {CARRY_W{1'b0}};
            hold_clr_s = 1'b1;
         end
         ACT_BUBBLE: begin
            valid_d      = 1'b0;
            payload_d    = NOP_PAYLOAD;
            carry_d      = carry_i;
            hold_inc_s   = 1'b1;
            bubble_inc_s = 1'b1;
         end
         ACT_ADVANCE: begin
            valid_d    = in_valid;
            payload_d  = in_payload;
            carry_d    = {CARRY_W{1'b0}};
            hold_clr_s = 1'b1;
         end
         ACT_HOLD: begin
            carry_d    = carry_i;
            hold_inc_s = 1'b1;
         end
         default: begin
            valid_d   = valid_q;
            payload_d = payload_q;
            carry_d   = carry_q;
         end
      endcase
   end

   // Slot registers, asynchronously forced to the NOP state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q   <= 1'b0;
         payload_q <= NOP_PAYLOAD;
         carry_q   <= {CARRY_W{1'b0}};
      end else begin
         valid_q   <= valid_d;
         payload_q <= payload_d;
         carry_q   <= carry_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_payload = payload_q;
   assign carry_o     = carry_q;

   sat_counter #(.W(CNT_W)) u_hold_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (hold_inc_s),
      .clr   (hold_clr_s),
      .count (hold_cnt)
   );

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (bubble_inc_s),
      .clr   (1'b0),
      .count (bubble_cnt)
   );

   pipe_stage_reg_chk u_chk (
      .clk (clk),
      .rst (rst),
      .up  (up_s),
      .dn  (dn_s)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios followed by
// randomized traffic, compared against a rule-level reference model.
// A second instance with 2-bit counters shares the stimulus to exercise
// counter saturation quickly.
module tb_pipe_stage_reg;

   localparam int PW = 104;
   localparam int CW = 66;

   logic          clk = 1'b0;
   logic          rst;
   logic [5:0]    stall;
   logic          flush;
   logic          in_valid;
   logic [PW-1:0] in_payload;
   logic [CW-1:0] carry_i;

   logic          out_valid,   s_out_valid;
   logic [PW-1:0] out_payload, s_out_payload;
   logic [CW-1:0] carry_o,     s_carry_o;
   logic [7:0]    hold_cnt,    bubble_cnt;
   logic [1:0]    s_hold_cnt,  s_bubble_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic          m_valid;
   logic [PW-1:0] m_payload;
   logic [CW-1:0] m_carry;
   int            m_hold, m_bubble, m_hold_s, m_bubble_s;

   always #5 clk = ~clk;

   pipe_stage_reg dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_payload(in_payload), .carry_i(carry_i),
      .out_valid(out_valid), .out_payload(out_payload), .carry_o(carry_o),
      .hold_cnt(hold_cnt), .bubble_cnt(bubble_cnt)
   );

   pipe_stage_reg #(.CNT_W(2)) dut_small (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_payload(in_payload), .carry_i(carry_i),
      .out_valid(s_out_valid), .out_payload(s_out_payload), .carry_o(s_carry_o),
      .hold_cnt(s_hold_cnt), .bubble_cnt(s_bubble_cnt)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int sat_inc(input int v, input int maxv);
      return (v >= maxv) ? maxv : v + 1;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_payload = '0; m_carry = '0;
      m_hold = 0; m_bubble = 0; m_hold_s = 0; m_bubble_s = 0;
   endtask

   // Apply the stage rules for the inputs present at the last edge
   task automatic model_update();
      logic up, dn;
      up = stall[3];
      dn = stall[4];
      if (flush) begin
         m_valid = 1'b0; m_payload = '0; m_carry = '0;
         m_hold = 0; m_hold_s = 0;
      end else if (up && !dn) begin
         m_valid = 1'b0; m_payload = '0; m_carry = carry_i;
         m_hold = sat_inc(m_hold, 255);     m_hold_s = sat_inc(m_hold_s, 3);
         m_bubble = sat_inc(m_bubble, 255); m_bubble_s = sat_inc(m_bubble_s, 3);
      end else if (!up) begin
         m_valid = in_valid; m_payload = in_payload; m_carry = '0;
         m_hold = 0; m_hold_s = 0;
      end else begin
         m_carry = carry_i;
         m_hold = sat_inc(m_hold, 255); m_hold_s = sat_inc(m_hold_s, 3);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"},    128'(out_valid),    128'(m_valid));
      chk({tag, ".payload"},  128'(out_payload),  128'(m_payload));
      chk({tag, ".carry"},    128'(carry_o),      128'(m_carry));
      chk({tag, ".hold"},     128'(hold_cnt),     128'(m_hold));
      chk({tag, ".bubble"},   128'(bubble_cnt),   128'(m_bubble));
      chk({tag, ".s_valid"},  128'(s_out_valid),  128'(m_valid));
      chk({tag, ".s_hold"},   128'(s_hold_cnt),   128'(m_hold_s));
      chk({tag, ".s_bubble"}, 128'(s_bubble_cnt), 128'(m_bubble_s));
   endtask

   task automatic step(input logic [5:0] st, input logic fl, input logic iv,
                       input logic [PW-1:0] ip, input logic [CW-1:0] ci, input string tag);
      stall = st; flush = fl; in_valid = iv; in_payload = ip; carry_i = ci;
      @(posedge clk);
      #1;
      model_update();
      check_all(tag);
   endtask

   // Assert reset between edges and confirm outputs clear before the next edge
   task automatic do_reset(input string tag);
      #2;
      rst = 1'b0;
      #1;
      chk({tag, ".async_valid"},   128'(out_valid),   128'(0));
      chk({tag, ".async_payload"}, 128'(out_payload), 128'(0));
      chk({tag, ".async_carry"},   128'(carry_o),     128'(0));
      chk({tag, ".async_hold"},    128'(hold_cnt),    128'(0));
      chk({tag, ".async_bubble"},  128'(bubble_cnt),  128'(0));
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      logic [127:0] r;
      logic [127:0] rc;
      logic [5:0]   st;
      logic         up;

      rst = 1'b0; stall = '0; flush = 1'b0; in_valid = 1'b0;
      in_payload = '0; carry_i = '0;
      model_reset();
      #3;
      check_all("reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;

      // advance
      step(6'b000000, 1'b0, 1'b1, 104'h1234, 66'h0, "adv");
      chk("adv_payload", 128'(out_payload), 128'h1234);
      chk("adv_valid",   128'(out_valid),   128'(1));
      chk("adv_carry",   128'(carry_o),     128'(0));

      // multi-cycle bubble with carry 1 then 2
      do_reset("rst1");
      step(6'b001111, 1'b0, 1'b1, 104'hAAAA, 66'h1, "mb1");
      chk("mb1_carry", 128'(carry_o), 128'(1));
      step(6'b001111, 1'b0, 1'b1, 104'hBBBB, 66'h2, "mb2");
      chk("mb2_carry",   128'(carry_o),    128'(2));
      chk("mb2_bubble",  128'(bubble_cnt), 128'(2));
      chk("mb2_hold",    128'(hold_cnt),   128'(2));
      chk("mb2_payload", 128'(out_payload), 128'(0));
      step(6'b000000, 1'b0, 1'b0, 104'h0, 66'h3, "mb3");
      chk("mb3_carry", 128'(carry_o),  128'(0));
      chk("mb3_hold",  128'(hold_cnt), 128'(0));

      // hold
      step(6'b000000, 1'b0, 1'b1, 104'hBEEF, 66'h0, "hl0");
      for (int i = 0; i < 3; i++)
         step(6'b011111, 1'b0, 1'b0, 104'(i + 7), 66'(i + 1), "hl");
      chk("hold_payload", 128'(out_payload), 128'hBEEF);
      chk("hold_valid",   128'(out_valid),   128'(1));
      chk("hold_cnt",     128'(hold_cnt),    128'(3));
      chk("hold_bubble",  128'(bubble_cnt),  128'(2));

      // flush beats stall
      step(6'b001111, 1'b1, 1'b1, 104'h77, 66'h3, "fl");
      chk("fl_valid",  128'(out_valid),  128'(0));
      chk("fl_carry",  128'(carry_o),    128'(0));
      chk("fl_hold",   128'(hold_cnt),   128'(0));
      chk("fl_bubble", 128'(bubble_cnt), 128'(2));

      // reset in the middle of a hold
      step(6'b000000, 1'b0, 1'b1, 104'h5A5A, 66'h0, "rh0");
      for (int i = 0; i < 5; i++)
         step(6'b011111, 1'b0, 1'b1, 104'h1, 66'h2A, "rh");
      chk("rh_hold",  128'(hold_cnt), 128'(5));
      chk("rh_carry", 128'(carry_o),  128'(66'h2A));
      do_reset("rst2");

      // saturation on the 2-bit instance
      for (int i = 0; i < 5; i++)
         step(6'b001111, 1'b0, 1'b1, 104'h9, 66'(i), "sat");
      chk("sat_s_bubble", 128'(s_bubble_cnt), 128'(3));
      chk("sat_s_hold",   128'(s_hold_cnt),   128'(3));
      chk("sat_bubble",   128'(bubble_cnt),   128'(5));

      // protocol violation behaves as advance
      step(6'b010000, 1'b0, 1'b1, 104'h55, 66'h7, "viol");
      chk("viol_valid",   128'(out_valid),   128'(1));
      chk("viol_payload", 128'(out_payload), 128'h55);
      chk("viol_carry",   128'(carry_o),     128'(0));

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         r  = {$urandom, $urandom, $urandom, $urandom};
         rc = {$urandom, $urandom, $urandom, $urandom};
         st = 6'($urandom);
         up = ($urandom_range(0, 3) != 0);
         st[3] = up;
         st[4] = up ? 1'($urandom) : ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 399) == 0) begin
            do_reset("rnd_rst");
         end
         step(st, ($urandom_range(0, 19) == 0), 1'($urandom), r[PW-1:0], rc[CW-1:0], "rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
